// File: rtl/task_icd_pkg.sv
// Shared constants for the host task interface: header layout, payload
// limits, the bank command opcode and the response codes returned to the host.
package task_icd_pkg;

    localparam logic [31:0] HEADER_BYTES      = 32'd8;
    localparam logic [31:0] MAX_PAYLOAD_WORDS = 32'd8;
    localparam logic [31:0] OP_BANK_CMD       = 32'h0000_0002;

    typedef enum logic [31:0] {
        TASK_VALID      = 32'd0,
        HEADER_INVALID  = 32'd1,
        PAYLOAD_INVALID = 32'd2,
        EXE_ERROR       = 32'd3
    } resp_code_e;

endpackage

// File: rtl/bank_task_deframer.sv
// Host task deframer in front of bank_cmd: parses opcode/length header,
// collects up to four bank/value pairs, dispatches them as a one-cycle strobe,
// then returns the bank_cmd response (or an error code) as one response word.
module bank_task_deframer
    import task_icd_pkg::*;
#(
    parameter int unsigned RESP_TIMEOUT = 200000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        asi_task_valid,
    output logic        asi_task_ready,
    input  logic [31:0] asi_task_data,
    input  logic        asi_task_eop,
    output logic        task_valid,
    output logic [31:0] len_bytes,
    output logic [31:0] bank0,
    output logic [31:0] bank1,
    output logic [31:0] bank2,
    output logic [31:0] bank3,
    output logic [31:0] val0,
    output logic [31:0] val1,
    output logic [31:0] val2,
    output logic [31:0] val3,
    input  logic        resp_valid,
    input  logic [31:0] resp,
    output logic        aso_resp_valid,
    input  logic        aso_resp_ready,
    output logic [31:0] aso_resp_data
);

    typedef enum logic [2:0] {
        IDLE,
        HDR_LEN,
        PAYLOAD,
        DISPATCH,
        WAIT_RESP,
        SEND_RESP,
        DRAIN
    } state_e;

    state_e      state;
    logic [31:0] opcode;
    logic [31:0] bank_r [4];
    logic [31:0] val_r  [4];
    logic [2:0]  idx;
    logic [3:0]  n_words;
    resp_code_e  pend_code;
    logic [31:0] tmo_cnt;

    logic        accept;
    logic [31:0] n_calc;
    logic        hdr_ok;

    // Input handshake is open only in the word-consuming states.
    assign asi_task_ready = rst_n && ((state == IDLE) || (state == HDR_LEN) ||
                                      (state == PAYLOAD) || (state == DRAIN));
    assign accept = asi_task_valid && asi_task_ready;

    // Header decode on the length word as it arrives.
    always_comb begin
        n_calc = (asi_task_data - HEADER_BYTES) >> 2;
        hdr_ok = (opcode == OP_BANK_CMD) &&
                 (asi_task_data[1:0] == 2'b00) &&
                 (asi_task_data >= HEADER_BYTES) &&
                 (n_calc <= MAX_PAYLOAD_WORDS);
    end

    assign bank0 = bank_r[0];
    assign bank1 = bank_r[1];
    assign bank2 = bank_r[2];
    assign bank3 = bank_r[3];
    assign val0  = val_r[0];
    assign val1  = val_r[1];
    assign val2  = val_r[2];
    assign val3  = val_r[3];

    // Frame parser, dispatch and response FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            opcode         <= '0;
            len_bytes      <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                bank_r[i] <= '0;
                val_r[i]  <= '0;
            end
            idx            <= '0;
            n_words        <= '0;
            pend_code      <= TASK_VALID;
            tmo_cnt        <= '0;
            task_valid     <= 1'b0;
            aso_resp_valid <= 1'b0;
            aso_resp_data  <= '0;
        end else begin
            task_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        opcode <= asi_task_data;
                        if (asi_task_eop) begin
                            aso_resp_valid <= 1'b1;
                            aso_resp_data  <= HEADER_INVALID;
                            state          <= SEND_RESP;
                        end else begin
                            state <= HDR_LEN;
                        end
                    end
                end
                HDR_LEN: begin
                    if (accept) begin
                        len_bytes <= asi_task_data;
                        for (int unsigned i = 0; i < 4; i++) begin
                            bank_r[i] <= '0;
                            val_r[i]  <= '0;
                        end
                        idx     <= '0;
                        n_words <= n_calc[3:0];
                        if (hdr_ok && (n_calc == '0) && asi_task_eop) begin
                            task_valid <= 1'b1;
                            state      <= DISPATCH;
                        end else if (hdr_ok && (n_calc != '0) && !asi_task_eop) begin
                            state <= PAYLOAD;
                        end else if (asi_task_eop) begin
                            aso_resp_valid <= 1'b1;
                            aso_resp_data  <= HEADER_INVALID;
                            state          <= SEND_RESP;
                        end else begin
                            pend_code <= HEADER_INVALID;
                            state     <= DRAIN;
                        end
                    end
                end
                PAYLOAD: begin
                    if (accept) begin
                        if (idx[0]) val_r[idx[2:1]]  <= asi_task_data;
                        else        bank_r[idx[2:1]] <= asi_task_data;
                        idx <= idx + 3'd1;
                        if (asi_task_eop) begin
                            if ({1'b0, idx} == n_words - 4'd1) begin
                                task_valid <= 1'b1;
                                state      <= DISPATCH;
                            end else begin
                                aso_resp_valid <= 1'b1;
                                aso_resp_data  <= HEADER_INVALID;
                                state          <= SEND_RESP;
                            end
                        end else if ({1'b0, idx} == n_words - 4'd1) begin
                            pend_code <= HEADER_INVALID;
                            state     <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (accept && asi_task_eop) begin
                        aso_resp_valid <= 1'b1;
                        aso_resp_data  <= pend_code;
                        state          <= SEND_RESP;
                    end
                end
                DISPATCH: begin
                    tmo_cnt <= '0;
                    state   <= WAIT_RESP;
                end
                WAIT_RESP: begin
                    // Counter holds ticks since dispatch; it stops at the limit so it cannot wrap.
                    if (resp_valid) begin
                        aso_resp_valid <= 1'b1;
                        aso_resp_data  <= resp;
                        state          <= SEND_RESP;
                    end else if (tmo_cnt + 32'd1 == RESP_TIMEOUT) begin
                        aso_resp_valid <= 1'b1;
                        aso_resp_data  <= EXE_ERROR;
                        state          <= SEND_RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
                end
                SEND_RESP: begin
                    if (aso_resp_ready) begin
                        aso_resp_valid <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bank_task_deframer.sv
// Self-checking bench for bank_task_deframer: directed frames from the test
// plan followed by randomized frames judged by a frame-level reference model.
module tb_bank_task_deframer;

    localparam int unsigned TMO = 50;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        asi_task_valid;
    logic        asi_task_ready;
    logic [31:0] asi_task_data;
    logic        asi_task_eop;
    logic        task_valid;
    logic [31:0] len_bytes;
    logic [31:0] bank0, bank1, bank2, bank3;
    logic [31:0] val0, val1, val2, val3;
    logic        resp_valid;
    logic [31:0] resp;
    logic        aso_resp_valid;
    logic        aso_resp_ready;
    logic [31:0] aso_resp_data;

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    bank_task_deframer #(.RESP_TIMEOUT(TMO)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .asi_task_valid (asi_task_valid),
        .asi_task_ready (asi_task_ready),
        .asi_task_data  (asi_task_data),
        .asi_task_eop   (asi_task_eop),
        .task_valid     (task_valid),
        .len_bytes      (len_bytes),
        .bank0          (bank0),
        .bank1          (bank1),
        .bank2          (bank2),
        .bank3          (bank3),
        .val0           (val0),
        .val1           (val1),
        .val2           (val2),
        .val3           (val3),
        .resp_valid     (resp_valid),
        .resp           (resp),
        .aso_resp_valid (aso_resp_valid),
        .aso_resp_ready (aso_resp_ready),
        .aso_resp_data  (aso_resp_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: a frame dispatches only if opcode, length rules and word count all agree.
    function automatic bit frame_ok(input logic [31:0] f[$]);
        logic [31:0] len;
        int unsigned n;
        if (f.size() < 2) return 1'b0;
        if (f[0] != 32'h2) return 1'b0;
        len = f[1];
        if ((len % 4) != 0 || len < 8) return 1'b0;
        n = (len - 8) / 4;
        if (n > 8) return 1'b0;
        return (f.size() == int'(2 + n));
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] f[$], input int unsigned k);
        return (int'(k) < f.size()) ? f[k] : 32'h0;
    endfunction

    // Called at a falling edge; returns at the falling edge after the word is taken.
    task automatic send_word(input logic [31:0] w, input logic e, output bit ok);
        bit taken;
        ok = 1'b0;
        asi_task_valid = 1'b1;
        asi_task_data  = w;
        asi_task_eop   = e;
        for (int t = 0; t < 100 && !ok; t++) begin
            taken = asi_task_ready;
            @(posedge clk);
            @(negedge clk);
            ok = taken;
        end
        asi_task_valid = 1'b0;
        asi_task_eop   = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] f[$], input bit gaps);
        bit ok;
        for (int i = 0; i < f.size(); i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            send_word(f[i], (i == f.size() - 1), ok);
            check("word_accepted", 32'(ok), 32'd1);
        end
    endtask

    task automatic recv_resp(input logic [31:0] exp, input int unsigned hold);
        logic [31:0] first;
        first = aso_resp_data;
        aso_resp_ready = 1'b0;
        for (int unsigned h = 0; h < hold; h++) begin
            check("resp_hold_valid", 32'(aso_resp_valid), 32'd1);
            check("resp_hold_stable", aso_resp_data, first);
            check("ready_low_in_resp", 32'(asi_task_ready), 32'd0);
            @(negedge clk);
        end
        check("resp_valid", 32'(aso_resp_valid), 32'd1);
        check("resp_data", aso_resp_data, exp);
        aso_resp_ready = 1'b1;
        @(negedge clk);
        aso_resp_ready = 1'b0;
        check("resp_single_xfer", 32'(aso_resp_valid), 32'd0);
        check("ready_after_resp", 32'(asi_task_ready), 32'd1);
    endtask

    // Full transaction: send, check dispatch fields, answer three cycles later, collect response.
    task automatic do_frame(input logic [31:0] f[$], input logic [31:0] rv,
                            input int unsigned hold, input bit gaps);
        bit ok;
        ok = frame_ok(f);
        send_frame(f, gaps);
        check("task_valid_rise", 32'(task_valid), 32'(ok));
        if (ok) begin
            check("len_bytes", len_bytes, f[1]);
            check("bank0", bank0, exp_word(f, 2));
            check("val0",  val0,  exp_word(f, 3));
            check("bank1", bank1, exp_word(f, 4));
            check("val1",  val1,  exp_word(f, 5));
            check("bank2", bank2, exp_word(f, 6));
            check("val2",  val2,  exp_word(f, 7));
            check("bank3", bank3, exp_word(f, 8));
            check("val3",  val3,  exp_word(f, 9));
            @(negedge clk);
            check("task_valid_pulse", 32'(task_valid), 32'd0);
            @(negedge clk);
            check("wait_no_resp", 32'(aso_resp_valid), 32'd0);
            check("wait_ready_low", 32'(asi_task_ready), 32'd0);
            @(negedge clk);
            resp_valid = 1'b1;
            resp       = rv;
            @(negedge clk);
            resp_valid = 1'b0;
            resp       = '0;
            recv_resp(rv, hold);
        end else begin
            recv_resp(32'd1, hold);
        end
    endtask

    initial begin
        logic [31:0] f[$];
        int unsigned cycles;
        int unsigned n, kind, cnt;

        rst_n = 1'b0;
        asi_task_valid = 1'b0;
        asi_task_data  = '0;
        asi_task_eop   = 1'b0;
        resp_valid     = 1'b0;
        resp           = '0;
        aso_resp_ready = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_ready", 32'(asi_task_ready), 32'd0);
        check("rst_task_valid", 32'(task_valid), 32'd0);
        check("rst_len", len_bytes, 32'd0);
        check("rst_bank0", bank0, 32'd0);
        check("rst_val3", val3, 32'd0);
        check("rst_resp_valid", 32'(aso_resp_valid), 32'd0);
        check("rst_resp_data", aso_resp_data, 32'd0);
        rst_n = 1'b1;
        #1;
        check("ready_after_rst", 32'(asi_task_ready), 32'd1);
        @(negedge clk);

        // Basic dispatch with two pairs.
        f = '{32'd2, 32'd24, 32'd1, 32'd5, 32'd2, 32'd9};
        do_frame(f, 32'd0, 0, 1'b0);

        // Wrong opcode: drained, header rejected.
        f = '{32'd7, 32'd16, 32'hAAAA, 32'hBBBB};
        do_frame(f, 32'd0, 1, 1'b0);

        // Frame cut short, then a normal frame.
        f = '{32'd2, 32'd24, 32'd1, 32'd5};
        do_frame(f, 32'd0, 0, 1'b0);
        f = '{32'd2, 32'd16, 32'h11, 32'h22};
        do_frame(f, 32'h1234_5678, 0, 1'b0);

        // Response withheld: limit reached TMO ticks after dispatch, code on the next cycle.
        f = '{32'd2, 32'd8};
        send_frame(f, 1'b0);
        check("tmo_task_valid", 32'(task_valid), 32'd1);
        cycles = 0;
        while (!aso_resp_valid && cycles < 200) begin
            @(negedge clk);
            cycles++;
        end
        check("tmo_latency", cycles, TMO + 1);
        recv_resp(32'd3, 20);

        // Reset during payload, then a full frame.
        f = '{32'd2, 32'd24, 32'd7, 32'd8};
        send_frame(f[0:2], 1'b0);
        asi_task_valid = 1'b1;
        asi_task_data  = f[3];
        rst_n = 1'b0;
        @(negedge clk);
        asi_task_valid = 1'b0;
        check("midrst_ready", 32'(asi_task_ready), 32'd0);
        check("midrst_len", len_bytes, 32'd0);
        check("midrst_bank0", bank0, 32'd0);
        check("midrst_val0", val0, 32'd0);
        check("midrst_task_valid", 32'(task_valid), 32'd0);
        check("midrst_resp_valid", 32'(aso_resp_valid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        f = '{32'd2, 32'd40, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
        do_frame(f, 32'h0000_00F0, 0, 1'b0);

        // Randomized frames of every shape.
        for (int r = 0; r < 40; r++) begin
            kind = $urandom_range(0, 6);
            n    = $urandom_range(0, 8);
            f    = {};
            f.push_back((kind == 2) ? 32'(2 + $urandom_range(1, 100)) : 32'd2);
            case (kind)
                3:       f.push_back(32'(8 + 4 * n + $urandom_range(1, 3)));
                6:       f.push_back(32'(44 + 4 * $urandom_range(0, 4)));
                default: f.push_back(32'(8 + 4 * n));
            endcase
            if (kind == 4) cnt = (n == 0) ? 0 : $urandom_range(0, n - 1);
            else if (kind == 5) cnt = n + $urandom_range(1, 3);
            else cnt = n;
            for (int unsigned k = 0; k < cnt; k++) f.push_back($urandom);
            if (kind == 4 && $urandom_range(0, 3) == 0) f = '{f[0]};
            do_frame(f, $urandom, $urandom_range(0, 3), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
